// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   WORD_AW            : width of a word (not byte) address
//   START_PC_DEFAULT   : default boot byte address
//   HALT_WORD_DEFAULT  : default instruction word that stops fetch
//   TIMEOUT_DEFAULT    : default WAIT cycle limit before a fetch error
//   fetch_state_e      : sequencer state encoding
package fetch_seq_pkg;

  localparam int unsigned WORD_AW           = 30;
  localparam logic [31:0] START_PC_DEFAULT  = 32'h0040_0020;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned TIMEOUT_DEFAULT   = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StHalt = 3'd4,
    StErr  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_npc_calc.sv
// Next-PC calculation: pc_word + 1 (+ sign-extended branch offset when taken).
//   pc_word  : current PC as a word address (pc[31:2])
//   br_taken : add the branch offset
//   br_imm16 : signed branch offset in words
//   npc      : next PC as a byte address, bits [1:0] always 00
module fetch_npc_calc
  import fetch_seq_pkg::*;
(
  input  logic [WORD_AW-1:0] pc_word,
  input  logic               br_taken,
  input  logic [15:0]        br_imm16,
  output logic [31:0]        npc
);

  logic [WORD_AW-1:0] imm_ext;
  logic [WORD_AW-1:0] offset;
  logic [WORD_AW-1:0] npc_word;

  sign_ext_30 u_sext (
    .imm (br_imm16),
    .ext (imm_ext)
  );

  assign offset = br_taken ? imm_ext : '0;

  // Carry-in supplies the sequential +1.
  full_adder_30 u_add (
    .a   (pc_word),
    .b   (offset),
    .cin (1'b1),
    .sum (npc_word)
  );

  assign npc = {npc_word, 2'b00};

endmodule

// File: rtl/full_adder_30.sv
// 30-bit adder with carry-in; carry-out is dropped (modulo 2^30 result).
//   a, b : addends
//   cin  : carry-in
//   sum  : (a + b + cin) mod 2^30
module full_adder_30 (
  input  logic [29:0] a,
  input  logic [29:0] b,
  input  logic        cin,
  output logic [29:0] sum
);

  assign sum = a + b + {29'd0, cin};

endmodule

// File: rtl/sign_ext_30.sv
// Sign-extends a 16-bit word offset to a 30-bit word offset.
//   imm : 16-bit signed offset
//   ext : 30-bit sign-extended offset
module sign_ext_30 (
  input  logic [15:0] imm,
  output logic [29:0] ext
);

  assign ext = {{14{imm[15]}}, imm};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one-cycle read requests to the
// instruction memory, waits for the response (with timeout), and presents the word
// to decode over a valid/ready handshake. Detects a halt word and memory timeout.
//   clk, reset               : clock, async active-high reset
//   run_en                   : permits new fetches
//   imem_req/addr            : read request strobe and byte address
//   imem_rdata/ack           : read response
//   if_valid/ready/instr/pc  : decode handshake and payload
//   br_taken/br_imm16        : branch outcome for the instruction being consumed
//   halted, fetch_err        : sticky status
//   instr_count              : instructions consumed by decode
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] START_PC  = START_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        br_taken,
  input  logic [15:0] br_imm16,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] instr_count
);

  // Last counter value before the limit; reaching it without ack ends in ERR.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]  count_q, count_d;
  logic         req_q, valid_q, halted_q, err_q;
  logic [31:0]  npc;

  fetch_npc_calc u_npc (
    .pc_word  (pc_q[31:2]),
    .br_taken (br_taken),
    .br_imm16 (br_imm16),
    .npc      (npc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    count_d    = count_q;
    unique case (state_q)
      StIdle: if (run_en) state_d = StReq;
      StReq: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        // Ack takes priority over a timeout in the same cycle.
        if (imem_ack) begin
          if (imem_rdata == HALT_WORD) begin
            state_d = StHalt;
          end else begin
            ir_d    = imem_rdata;
            state_d = StHold;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == TimeoutLast) state_d = StErr;
        end
      end
      StHold: begin
        if (if_ready) begin
          pc_d    = npc;
          count_d = count_q + 32'd1;
          state_d = run_en ? StReq : StIdle;
        end
      end
      StHalt, StErr: state_d = state_q;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= START_PC;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      req_q      <= (state_d == StReq);
      valid_q    <= (state_d == StHold);
      halted_q   <= (state_d == StHalt);
      err_q      <= (state_d == StErr);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = ir_q;
  assign if_pc       = pc_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A small memory responder acks each request
// after mem_lat cycles with data = addr ^ 0xA5A50000 (or HALT_WORD at halt_addr).
// Stimulus and checks run on the falling edge; the responder runs 1 ns after rising.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        br_taken;
  logic [15:0] br_imm16;
  logic        halted;
  logic        fetch_err;
  logic [31:0] instr_count;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Responder controls and state
  int          mem_lat   = 1;
  bit          mem_on    = 1'b1;
  bit          force_ack = 1'b0;
  logic [31:0] halt_addr = 32'h0;
  logic [31:0] addr_lat  = 32'h0;
  int          cd        = 0;
  int          req_cnt   = 0;
  logic [31:0] req_log[$];

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run_en      (run_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .br_taken    (br_taken),
    .br_imm16    (br_imm16),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == halt_addr) return 32'hFFFF_FFFF;
    return addr ^ 32'hA5A5_0000;
  endfunction

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = force_ack;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && mem_on) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(addr_lat);
        end
      end
      if (imem_req) begin
        addr_lat = imem_addr;
        cd       = mem_lat;
        req_cnt++;
        req_log.push_back(imem_addr);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      @(negedge clk);
    end
    check_eq("wait_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check_eq("wait_req", 32'(imem_req), 32'd1);
  endtask

  task automatic consume(input logic taken, input logic [15:0] imm);
    if_ready = 1'b1;
    br_taken = taken;
    br_imm16 = imm;
    @(negedge clk);
    if_ready = 1'b0;
    br_taken = 1'b0;
    br_imm16 = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [8:0]  vpat;
    int          snap;
    reset    = 1'b1;
    run_en   = 1'b0;
    if_ready = 1'b0;
    br_taken = 1'b0;
    br_imm16 = 16'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_imem_addr", imem_addr, 32'h0040_0020);
    check_eq("rst_if_pc", if_pc, 32'h0040_0020);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_outs", {imem_req, if_valid, halted, fetch_err}, 32'h0);
    check_eq("rst_count", instr_count, 32'h0);

    // 1: back-to-back fetch, ack latency 1, decode always ready
    if_ready = 1'b1;
    run_en   = 1'b1;
    reset    = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vpat[i] = if_valid;
      if (i == 2) begin
        check_eq("t1_first_instr", if_instr, 32'hA5E5_0020);
        check_eq("t1_first_pc", if_pc, 32'h0040_0020);
      end
    end
    check_eq("t1_valid_pattern", 32'(vpat), 32'h124);
    run_en = 1'b0;
    @(negedge clk);
    if_ready = 1'b0;
    check_eq("t1_count", instr_count, 32'd3);
    check_eq("t1_req_count", req_log.size(), 32'd3);
    check_eq("t1_addr0", req_log[0], 32'h0040_0020);
    check_eq("t1_addr1", req_log[1], 32'h0040_0024);
    check_eq("t1_addr2", req_log[2], 32'h0040_0028);

    // 2: branches from pc 0x30, backward (-2) and forward (+4)
    run_en = 1'b1;
    wait_valid();
    check_eq("t2_pc_2c", if_pc, 32'h0040_002C);
    consume(1'b0, 16'h0);
    wait_valid();
    check_eq("t2_pc_30a", if_pc, 32'h0040_0030);
    consume(1'b1, 16'hFFFE);
    wait_req();
    check_eq("t2_br_back", imem_addr, 32'h0040_002C);
    wait_valid();
    consume(1'b0, 16'h0);
    wait_valid();
    check_eq("t2_pc_30b", if_pc, 32'h0040_0030);
    consume(1'b1, 16'h0004);
    wait_req();
    check_eq("t2_br_fwd", imem_addr, 32'h0040_0044);

    // 3: stall in HOLD; branch inputs toggled during stall must be ignored
    wait_valid();
    br_taken = 1'b1;
    br_imm16 = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_instr", if_instr, 32'hA5E5_0044);
      check_eq("t3_pc", if_pc, 32'h0040_0044);
      check_eq("t3_no_req", 32'(imem_req), 32'd0);
      check_eq("t3_count", instr_count, 32'd7);
      @(negedge clk);
    end
    run_en = 1'b0;
    consume(1'b0, 16'h0);
    check_eq("t3_count_inc", instr_count, 32'd8);
    check_eq("t3_valid_drop", 32'(if_valid), 32'd0);

    // 4: halt word at 0x48
    halt_addr = 32'h0040_0048;
    run_en    = 1'b1;
    wait_req();
    check_eq("t4_addr", imem_addr, 32'h0040_0048);
    snap = req_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t4_no_valid", 32'(if_valid), 32'd0);
    end
    check_eq("t4_halted", 32'(halted), 32'd1);
    check_eq("t4_no_more_req", 32'(req_cnt), 32'(snap));
    check_eq("t4_count", instr_count, 32'd8);

    // 5: timeout after 16 WAIT cycles, late ack ignored, reset recovers
    reset  = 1'b1;
    run_en = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_halted", 32'(halted), 32'd0);
    check_eq("t5_rst_count", instr_count, 32'd0);
    mem_on = 1'b0;
    reset  = 1'b0;
    run_en = 1'b1;
    wait_req();
    check_eq("t5_addr", imem_addr, 32'h0040_0020);
    for (int i = 0; i < 16; i++) @(negedge clk);
    check_eq("t5_err_not_yet", 32'(fetch_err), 32'd0);
    @(negedge clk);
    check_eq("t5_err", 32'(fetch_err), 32'd1);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    check_eq("t5_err_sticky", 32'(fetch_err), 32'd1);
    check_eq("t5_late_ack", {if_valid, imem_req, halted}, 32'h0);
    reset  = 1'b1;
    run_en = 1'b0;
    @(negedge clk);
    check_eq("t5_err_clear", 32'(fetch_err), 32'd0);
    mem_on  = 1'b1;
    mem_lat = 5;
    reset   = 1'b0;
    run_en  = 1'b1;
    wait_req();
    check_eq("t5_restart_addr", imem_addr, 32'h0040_0020);

    // 6: reset mid-WAIT, stale ack arrives in IDLE
    @(negedge clk);
    run_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t6_no_valid", 32'(if_valid), 32'd0);
      check_eq("t6_no_req", 32'(imem_req), 32'd0);
    end
    check_eq("t6_pc", if_pc, 32'h0040_0020);
    check_eq("t6_ir", if_instr, 32'h0);
    check_eq("t6_count", instr_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
